// File: rtl/lsq_dcache_port.sv
// Single-issue LSQ-to-dcache request port: holds one request and retries it until it is accepted.
// Tracks outstanding load misses by memory tag and reports completions on registered load and store buses.
module lsq_dcache_port #(
  parameter int NUM_MISS     = 4,
  parameter int ROB_TAG_BITS = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    lsq_req_valid,
  input  logic                    lsq_req_is_store,
  input  logic [63:0]             lsq_req_addr,
  input  logic [63:0]             lsq_req_data,
  input  logic [ROB_TAG_BITS-1:0] lsq_req_rob_tag,
  output logic                    lsq_req_ready,
  input  logic                    lsq_flush,
  output logic [1:0]              proc2Dcache_command,
  output logic [63:0]             proc2Dcache_addr,
  output logic [63:0]             proc2Dcache_data,
  input  logic [63:0]             Dcache2proc_data,
  input  logic                    Dcache2proc_valid,
  input  logic [3:0]              Dcache2proc_tag,
  input  logic [3:0]              Dmem2Dcache_response,
  input  logic [3:0]              Dmem2Dcache_tag,
  output logic                    cdb_valid,
  output logic [ROB_TAG_BITS-1:0] cdb_rob_tag,
  output logic [63:0]             cdb_data,
  output logic                    st_done_valid,
  output logic [ROB_TAG_BITS-1:0] st_done_rob_tag,
  output logic                    miss_full
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic                    slot_valid_q, slot_valid_d;
  logic                    slot_is_store_q, slot_is_store_d;
  logic [63:0]             slot_addr_q, slot_addr_d;
  logic [63:0]             slot_data_q, slot_data_d;
  logic [ROB_TAG_BITS-1:0] slot_rob_q, slot_rob_d;

  logic [NUM_MISS-1:0]     miss_valid_q, miss_valid_d;
  logic [3:0]              miss_mem_tag_q [NUM_MISS];
  logic [ROB_TAG_BITS-1:0] miss_rob_q [NUM_MISS];
  logic [NUM_MISS-1:0]     match_vec, free_oh, alloc_vec;

  logic                    cdb_valid_d, st_done_valid_d;
  logic [ROB_TAG_BITS-1:0] cdb_rob_d, fill_rob;
  logic                    fill, issue, hit, miss_acc, store_retire, retire, accept, fill_hit;

  // A fill owns the cache this cycle; a load also waits when no miss entry is free.
  assign miss_full    = &miss_valid_q;
  assign fill         = (Dmem2Dcache_tag != 4'd0);
  assign issue        = slot_valid_q && !fill && !(!slot_is_store_q && miss_full);
  assign hit          = issue && !slot_is_store_q && Dcache2proc_valid && (Dcache2proc_tag == 4'd0);
  assign miss_acc     = issue && !slot_is_store_q && !Dcache2proc_valid && (Dcache2proc_tag != 4'd0);
  assign store_retire = issue && slot_is_store_q && (Dmem2Dcache_response != 4'd0);
  assign retire       = hit || miss_acc || store_retire;
  assign accept       = lsq_req_valid && lsq_req_ready && !lsq_flush;
  assign fill_hit     = fill && Dcache2proc_valid && (|match_vec);
  assign alloc_vec    = miss_acc ? free_oh : '0;

  assign lsq_req_ready       = !slot_valid_q || retire;
  assign proc2Dcache_command = !issue ? BUS_NONE : (slot_is_store_q ? BUS_STORE : BUS_LOAD);
  assign proc2Dcache_addr    = slot_addr_q;
  assign proc2Dcache_data    = slot_data_q;

  generate
    for (genvar gi = 0; gi < NUM_MISS; gi++) begin : g_miss
      assign match_vec[gi] = miss_valid_q[gi] && (miss_mem_tag_q[gi] == Dcache2proc_tag);

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          miss_mem_tag_q[gi] <= '0;
          miss_rob_q[gi]     <= '0;
        end else if (alloc_vec[gi]) begin
          miss_mem_tag_q[gi] <= Dcache2proc_tag;
          miss_rob_q[gi]     <= slot_rob_q;
        end
      end
    end
  endgenerate

  always_comb begin
    free_oh = '0;
    for (int i = 0; i < NUM_MISS; i++) begin
      if (!miss_valid_q[i] && (free_oh == '0)) free_oh[i] = 1'b1;
    end
  end

  // Memory never reuses an outstanding tag, so at most one entry can match.
  always_comb begin
    fill_rob = '0;
    for (int i = 0; i < NUM_MISS; i++) begin
      if (match_vec[i]) fill_rob = miss_rob_q[i];
    end
  end

  always_comb begin
    miss_valid_d = miss_valid_q;
    if (lsq_flush) begin
      miss_valid_d = '0;
    end else begin
      if (fill_hit) miss_valid_d = miss_valid_d & ~match_vec;
      miss_valid_d = miss_valid_d | alloc_vec;
    end
  end

  always_comb begin
    slot_valid_d    = slot_valid_q;
    slot_is_store_d = slot_is_store_q;
    slot_addr_d     = slot_addr_q;
    slot_data_d     = slot_data_q;
    slot_rob_d      = slot_rob_q;
    if (lsq_flush) begin
      slot_valid_d = 1'b0;
    end else if (accept) begin
      slot_valid_d    = 1'b1;
      slot_is_store_d = lsq_req_is_store;
      slot_addr_d     = lsq_req_addr;
      slot_data_d     = lsq_req_data;
      slot_rob_d      = lsq_req_rob_tag;
    end else if (retire) begin
      slot_valid_d = 1'b0;
    end
  end

  // Hits and fills never coincide (a fill blocks issue), so one CDB port suffices.
  always_comb begin
    cdb_valid_d     = !lsq_flush && (hit || fill_hit);
    cdb_rob_d       = hit ? slot_rob_q : fill_rob;
    st_done_valid_d = !lsq_flush && store_retire;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid_q    <= 1'b0;
      slot_is_store_q <= 1'b0;
      slot_addr_q     <= '0;
      slot_data_q     <= '0;
      slot_rob_q      <= '0;
      miss_valid_q    <= '0;
      cdb_valid       <= 1'b0;
      cdb_rob_tag     <= '0;
      cdb_data        <= '0;
      st_done_valid   <= 1'b0;
      st_done_rob_tag <= '0;
    end else begin
      slot_valid_q    <= slot_valid_d;
      slot_is_store_q <= slot_is_store_d;
      slot_addr_q     <= slot_addr_d;
      slot_data_q     <= slot_data_d;
      slot_rob_q      <= slot_rob_d;
      miss_valid_q    <= miss_valid_d;
      cdb_valid       <= cdb_valid_d;
      st_done_valid   <= st_done_valid_d;
      if (cdb_valid_d) begin
        cdb_rob_tag <= cdb_rob_d;
        cdb_data    <= Dcache2proc_data;
      end
      if (st_done_valid_d) st_done_rob_tag <= slot_rob_q;
    end
  end

endmodule

// File: tb/tb_lsq_dcache_port.sv
// Randomized bench for lsq_dcache_port: a transaction-level model predicts commands and completions,
// and a monitor matches the completion buses against queued expectations.
module tb_lsq_dcache_port;
  localparam int NUM_MISS = 4;
  localparam int RB       = 5;
  localparam int N_CYC    = 2000;

  logic          clock = 1'b0;
  logic          reset;
  logic          lsq_req_valid, lsq_req_is_store, lsq_flush;
  logic [63:0]   lsq_req_addr, lsq_req_data;
  logic [RB-1:0] lsq_req_rob_tag;
  logic          lsq_req_ready;
  logic [1:0]    proc2Dcache_command;
  logic [63:0]   proc2Dcache_addr, proc2Dcache_data;
  logic [63:0]   Dcache2proc_data;
  logic          Dcache2proc_valid;
  logic [3:0]    Dcache2proc_tag, Dmem2Dcache_response, Dmem2Dcache_tag;
  logic          cdb_valid, st_done_valid, miss_full;
  logic [RB-1:0] cdb_rob_tag, st_done_rob_tag;
  logic [63:0]   cdb_data;

  lsq_dcache_port #(.NUM_MISS(NUM_MISS), .ROB_TAG_BITS(RB)) dut (
    .clock(clock), .reset(reset),
    .lsq_req_valid(lsq_req_valid), .lsq_req_is_store(lsq_req_is_store),
    .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data),
    .lsq_req_rob_tag(lsq_req_rob_tag), .lsq_req_ready(lsq_req_ready),
    .lsq_flush(lsq_flush),
    .proc2Dcache_command(proc2Dcache_command), .proc2Dcache_addr(proc2Dcache_addr),
    .proc2Dcache_data(proc2Dcache_data),
    .Dcache2proc_data(Dcache2proc_data), .Dcache2proc_valid(Dcache2proc_valid),
    .Dcache2proc_tag(Dcache2proc_tag), .Dmem2Dcache_response(Dmem2Dcache_response),
    .Dmem2Dcache_tag(Dmem2Dcache_tag),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_data(cdb_data),
    .st_done_valid(st_done_valid), .st_done_rob_tag(st_done_rob_tag),
    .miss_full(miss_full)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int due; logic [RB-1:0] rob; logic [63:0] data; } cdb_t;
  typedef struct { int due; logic [RB-1:0] rob; } st_t;
  cdb_t cdb_q[$];
  st_t  st_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference state: one request slot, and outstanding misses keyed by memory tag.
  bit            m_sv, m_sst;
  logic [63:0]   m_sa, m_sd;
  logic [RB-1:0] m_sr;
  logic [RB-1:0] m_miss[int];
  bit            inflight[int];

  cdb_t mon_c;
  st_t  mon_s;
  bit   exp_c, exp_s;

  always @(negedge clock) begin
    if (!reset) begin
      exp_c = (cdb_q.size() > 0) && (cdb_q[0].due <= cyc);
      if (cdb_valid || exp_c) begin
        check("cdb_valid", cdb_valid, exp_c);
        if (exp_c) begin
          mon_c = cdb_q.pop_front();
          if (cdb_valid) begin
            check("cdb_rob", cdb_rob_tag, mon_c.rob);
            check("cdb_data", cdb_data, mon_c.data);
            $display("cdb   cyc %0d rob %0d data %h", cyc, cdb_rob_tag, cdb_data);
          end
        end
      end
      exp_s = (st_q.size() > 0) && (st_q[0].due <= cyc);
      if (st_done_valid || exp_s) begin
        check("st_done_valid", st_done_valid, exp_s);
        if (exp_s) begin
          mon_s = st_q.pop_front();
          if (st_done_valid) begin
            check("st_done_rob", st_done_rob_tag, mon_s.rob);
            $display("store cyc %0d rob %0d", cyc, st_done_rob_tag);
          end
        end
      end
    end
  end

  task automatic do_cycle(input bit allow, input bit force_flush);
    int  keys[$];
    int  t, start;
    bit  fill, issue, hit, miss, st, retire, exp_ready, full;
    logic [1:0] exp_cmd;
    @(negedge clock);
    lsq_req_valid    = allow && ($urandom_range(0, 9) < 7);
    lsq_req_is_store = ($urandom_range(0, 3) == 0);
    lsq_req_addr     = {$urandom, $urandom};
    lsq_req_data     = {$urandom, $urandom};
    lsq_req_rob_tag  = RB'($urandom);
    lsq_flush        = force_flush || (allow && $urandom_range(0, 59) == 0);
    Dmem2Dcache_tag      = 4'd0;
    Dmem2Dcache_response = 4'd0;
    Dcache2proc_valid    = 1'b0;
    Dcache2proc_tag      = 4'd0;
    Dcache2proc_data     = {$urandom, $urandom};
    full = (m_miss.num() == NUM_MISS);

    // Memory/cache environment: either return a fill for an in-flight tag, or answer the slot's command.
    if (allow && inflight.num() > 0 && $urandom_range(0, 3) == 0) begin
      foreach (inflight[k]) keys.push_back(k);
      t = keys[$urandom_range(0, keys.size() - 1)];
      inflight.delete(t);
      Dmem2Dcache_tag   = 4'(t);
      Dcache2proc_valid = 1'b1;
      Dcache2proc_tag   = 4'(t);
    end else if (m_sv && !m_sst && !full) begin
      case ($urandom_range(0, 2))
        0: Dcache2proc_valid = 1'b1;
        1: begin
          start = $urandom_range(1, 15);
          for (int j = 0; j < 15; j++) begin
            t = ((start - 1 + j) % 15) + 1;
            if (!inflight.exists(t) && Dcache2proc_tag == 4'd0) begin
              Dcache2proc_tag      = 4'(t);
              Dmem2Dcache_response = 4'(t);
              inflight[t]          = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else if (m_sv && m_sst) begin
      if ($urandom_range(0, 1) == 1) Dmem2Dcache_response = 4'($urandom_range(1, 15));
    end

    #1;
    fill      = (Dmem2Dcache_tag != 4'd0);
    issue     = m_sv && !fill && !(!m_sst && full);
    exp_cmd   = !issue ? 2'd0 : (m_sst ? 2'd2 : 2'd1);
    hit       = issue && !m_sst && Dcache2proc_valid && Dcache2proc_tag == 4'd0;
    miss      = issue && !m_sst && !Dcache2proc_valid && Dcache2proc_tag != 4'd0;
    st        = issue && m_sst && Dmem2Dcache_response != 4'd0;
    retire    = hit || miss || st;
    exp_ready = !m_sv || retire;

    check("command", proc2Dcache_command, exp_cmd);
    check("ready", lsq_req_ready, exp_ready);
    check("miss_full", miss_full, full);
    if (exp_cmd != 2'd0) check("addr", proc2Dcache_addr, m_sa);
    if (exp_cmd == 2'd2) check("st_data", proc2Dcache_data, m_sd);

    if (!lsq_flush) begin
      if (hit) cdb_q.push_back('{cyc + 1, m_sr, Dcache2proc_data});
      if (st)  st_q.push_back('{cyc + 1, m_sr});
      if (fill && m_miss.exists(int'(Dmem2Dcache_tag)))
        cdb_q.push_back('{cyc + 1, m_miss[int'(Dmem2Dcache_tag)], Dcache2proc_data});
    end
    if (fill) m_miss.delete(int'(Dmem2Dcache_tag));
    if (miss) m_miss[int'(Dcache2proc_tag)] = m_sr;
    if (lsq_flush) begin
      m_miss.delete();
      m_sv = 1'b0;
    end else if (lsq_req_valid && exp_ready) begin
      m_sv = 1'b1; m_sst = lsq_req_is_store; m_sa = lsq_req_addr;
      m_sd = lsq_req_data; m_sr = lsq_req_rob_tag;
    end else if (retire) begin
      m_sv = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_cdb_valid"}, cdb_valid, 1'b0);
    check({tagname, "_st_done"}, st_done_valid, 1'b0);
    check({tagname, "_ready"}, lsq_req_ready, 1'b1);
    check({tagname, "_command"}, proc2Dcache_command, 2'd0);
    check({tagname, "_miss_full"}, miss_full, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    lsq_req_valid = 0; lsq_req_is_store = 0; lsq_req_addr = '0; lsq_req_data = '0;
    lsq_req_rob_tag = '0; lsq_flush = 0;
    Dcache2proc_data = '0; Dcache2proc_valid = 0; Dcache2proc_tag = '0;
    Dmem2Dcache_response = '0; Dmem2Dcache_tag = '0;
    m_sv = 0; m_sst = 0; m_sa = '0; m_sd = '0; m_sr = '0;
    #3;
    check_reset_outputs("reset");
    #4;
    reset = 1'b0;

    for (int c = 0; c < N_CYC; c++) begin
      do_cycle(1'b1, 1'b0);
      if (c == N_CYC / 2) begin
        // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        m_sv = 0;
        m_miss.delete();
        cdb_q.delete();
        st_q.delete();
        #1 reset = 1'b0;
      end
    end

    do_cycle(1'b0, 1'b1);
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
    @(negedge clock);
    #1;
    check("drain_cdb_queue", 64'(cdb_q.size()), 64'd0);
    check("drain_st_queue", 64'(st_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsq_dcache_port.md
# lsq_dcache_port

Single-issue request port between the load/store queue and `dcache`. It holds one LSQ request and drives `dcache` with it, retrying until the cache or memory accepts it. It tracks outstanding load misses by memory tag and returns completed load data, tagged with the ROB tag, on a registered completion bus. It also reports completed stores to the LSQ.

## Interface
- `NUM_MISS`, 4: miss-table entries (outstanding load misses).
- `ROB_TAG_BITS`, 5: ROB tag width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `lsq_req_valid`  in  1  LSQ presents a request.
- `lsq_req_is_store`  in  1  1 = store, 0 = load.
- `lsq_req_addr`  in  64  byte address.
- `lsq_req_data`  in  64  store data.
- `lsq_req_rob_tag`  in  ROB_TAG_BITS  owner ROB tag.
- `lsq_req_ready`  out  1  request accepted at this edge when high with valid.
- `lsq_flush`  in  1  mispredict flush: drop slot and all miss entries.
- `proc2Dcache_command`  out  2  `BUS_NONE`/`BUS_LOAD`/`BUS_STORE`.
- `proc2Dcache_addr`  out  64  slot address.
- `proc2Dcache_data`  out  64  slot store data.
- `Dcache2proc_data`  in  64  load data (hit or fill).
- `Dcache2proc_valid`  in  1  data valid.
- `Dcache2proc_tag`  in  4  0 = hit/none; nonzero = miss tag (issue) or fill tag (fill).
- `Dmem2Dcache_response`  in  4  memory accept tag this cycle; 0 = rejected.
- `Dmem2Dcache_tag`  in  4  nonzero = fill in progress; the cache ignores proc commands this cycle.
- `cdb_valid`  out  1  registered load completion.
- `cdb_rob_tag`  out  ROB_TAG_BITS  completing ROB tag.
- `cdb_data`  out  64  load value.
- `st_done_valid`  out  1  registered store completion.
- `st_done_rob_tag`  out  ROB_TAG_BITS  completing store ROB tag.
- `miss_full`  out  1  all miss entries are valid.

## Operation
- State: the issue slot {valid, is_store, addr, data, rob_tag}; the miss table has `NUM_MISS` × {valid, mem_tag[3:0], rob_tag}.
- `fill` = (`Dmem2Dcache_tag` != 0).
- Command drive:
  - `BUS_NONE` when the slot is empty, when `fill` is high, or when a load is in the slot and `miss_full` is high.
  - Otherwise `BUS_LOAD` or `BUS_STORE`, with the slot's addr and data.
- Slot retirement (`retire`) happens only in a cycle where the command is not `BUS_NONE`:
  - Load hit: `Dcache2proc_valid` && `Dcache2proc_tag` == 0. Schedule a CDB write with `Dcache2proc_data`.
  - Load miss accepted: `Dcache2proc_valid` == 0 and `Dcache2proc_tag` != 0. Allocate the lowest free miss entry with {mem_tag = `Dcache2proc_tag`, rob_tag}.
  - Load miss rejected: `Dcache2proc_tag` == 0 and not valid. The slot holds and retries next cycle.
  - Store: retires iff `Dmem2Dcache_response` != 0. Schedule `st_done`. If the response is 0, the slot retries.
- Fill: when `fill` is high and `Dcache2proc_valid` is high, search the miss table for a valid entry whose mem_tag equals `Dcache2proc_tag`.
  - On a match, schedule a CDB write with the entry's rob_tag and `Dcache2proc_data`, and clear the entry.
  - With no match (flushed load), the data is dropped silently.
- Memory never reuses a tag that is still outstanding, so at most one entry matches.
- `lsq_req_ready` = !slot.valid || retire. This is combinational and allows back-to-back requests.
- Hit completion and fill completion never coincide, because a fill blocks issue. A single CDB port therefore suffices.
- `lsq_flush`, at the edge:
  - Clears slot.valid and all miss.valid, and blocks acceptance of a new request.
  - `cdb_valid` and `st_done_valid` are forced to 0 at the next edge.
  - A store already accepted by memory is not undone.
- Reset clears the slot, the miss table, and all registered outputs. During reset, `lsq_req_ready` is 1 and the command is `BUS_NONE`.

## Timing
- Request accepted at edge E0. Issued to `dcache` in cycle E0+1, combinationally from the slot.
- Hit: `cdb_valid` is high for one cycle, starting at edge E0+2.
- Store: `st_done_valid` is high for one cycle, starting at the edge after memory accepts.
- Miss: fill seen in cycle F gives `cdb_valid` in cycle F+1.
- Each fill cycle delays an issue by 1 cycle. Each memory reject delays it by 1 cycle.
- A full miss table stalls loads only. A store in the slot still issues.
- Reset values: all outputs 0, except `lsq_req_ready` = 1 and `proc2Dcache_command` = `BUS_NONE`.

## Test plan
- Load hit: load to addr 0x100, rob 3; `dcache` returns valid, tag 0, data 0xDEAD. Required: `cdb_valid` 2 cycles after acceptance, rob 3, data 0xDEAD; miss table unchanged.
- Miss then fill: load to 0x208, rob 7; `dcache` returns tag 5, invalid. Entry 0 = {5, 7}. Later `Dmem2Dcache_tag` = 5 with data 0x1234. Required: next cycle `cdb_valid`, rob 7, 0x1234; entry freed.
- Store retry: store rob 2 with `Dmem2Dcache_response` = 0 for 3 cycles, then 9. Required: `BUS_STORE` held for 4 cycles, `lsq_req_ready` low until the accept cycle, `st_done_valid` rob 2 once.
- Fill collision: slot holds a load while `Dmem2Dcache_tag` = 4 for 1 cycle. Required: command `BUS_NONE` that cycle, load issued the next cycle, fill completion on the CDB first.
- Miss table full: 4 misses with tags 1–4; a 5th load is held with `BUS_NONE` and `miss_full` = 1. A store queued behind it is still blocked (single slot). Required: fill of tag 2 frees an entry, and the 5th load issues the following cycle.
- Flush/reset mid-flight: 2 outstanding misses, `lsq_flush` asserted, then fills for their tags. Required: no `cdb_valid`. An asynchronous reset asserted mid-cycle clears outputs immediately, without waiting for a clock edge.
